// File: rtl/display_scan.sv
`default_nettype none
// ============================================================================
//  Module   : display_scan
//  Purpose  : Time-multiplexed scan controller for an N-digit common-anode
//             seven-segment display. Holds a shadow copy of the digit words,
//             applies optional leading-zero blanking and drives active-low
//             anode enables with a dead-time at the start of every slot.
//  Revision : 1.0  initial release
// ============================================================================
module display_scan #(
  parameter int NDIGITS  = 8,
  parameter int CLKFREQ  = 100_000_000,
  parameter int SCANFREQ = 1000,
  parameter int DEAD     = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load,
  input  logic [7*NDIGITS-1:0]       d_in,
  input  logic                       lz_en,
  output logic [6:0]                 data,
  output logic [NDIGITS-1:0]         an_n,
  output logic [$clog2(NDIGITS)-1:0] digit
);

  localparam int DIV = CLKFREQ / SCANFREQ;
  localparam int CW  = $clog2(DIV);
  localparam int IW  = $clog2(NDIGITS);

  localparam logic [CW-1:0] C_CNT_MAX  = CW'(DIV - 1);
  localparam logic [IW-1:0] C_LAST_IDX = IW'(NDIGITS - 1);
  localparam logic [6:0]    C_BLANK    = 7'h40;

  logic [CW-1:0]      r_cnt;
  logic [IW-1:0]      r_idx;
  logic [6:0]         r_shadow [NDIGITS];
  logic [NDIGITS-1:0] r_mask;

  logic [6:0]         w_din [NDIGITS];
  logic [NDIGITS-1:0] w_lzb;
  logic               w_run;
  logic               w_dead;
  logic [6:0]         w_eff;

  // Split the flat input bus into per-digit words
  genvar gk;
  generate
    for (gk = 0; gk < NDIGITS; gk++) begin : g_unpack
      assign w_din[gk] = d_in[7*gk +: 7];
    end
  endgenerate

  // Dead-time window: the first DEAD clocks of each slot keep all anodes off
  generate
    if (DEAD == 0) begin : g_no_dead
      assign w_dead = 1'b0;
    end else begin : g_dead
      assign w_dead = (r_cnt < CW'(DEAD));
    end
  endgenerate

  // Leading-zero mask: walk down from the top digit while words are zero or blank
  always_comb begin
    w_run = 1'b1;
    w_lzb = '0;
    for (int k = NDIGITS - 1; k >= 1; k--) begin
      w_run    = w_run & ((w_din[k] == 7'h00) | w_din[k][6]);
      w_lzb[k] = w_run;
    end
  end

  // Word presented for the digit currently being scanned
  assign w_eff = r_mask[r_idx] ? C_BLANK : r_shadow[r_idx];

  // Slot prescaler and digit index
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (r_cnt == C_CNT_MAX) begin
      r_cnt <= '0;
      r_idx <= (r_idx == C_LAST_IDX) ? '0 : r_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Shadow words and blank mask, captured on the load strobe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NDIGITS; k++) begin
        r_shadow[k] <= C_BLANK;
      end
      r_mask <= '0;
    end else if (load) begin
      for (int k = 0; k < NDIGITS; k++) begin
        r_shadow[k] <= w_din[k];
      end
      r_mask <= lz_en ? w_lzb : '0;
    end
  end

  // Registered outputs, lagging the prescaler state by one clock
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data  <= C_BLANK;
      an_n  <= '1;
      digit <= '0;
    end else begin
      data  <= w_eff;
      digit <= r_idx;
      an_n  <= w_dead ? '1 : ~({{(NDIGITS-1){1'b0}}, 1'b1} << r_idx);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_display_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_display_scan
//  Purpose  : Directed self-checking bench for display_scan
//             (NDIGITS=4, DIV=4, DEAD=1).
//  Revision : 1.0  initial release
// ============================================================================
module tb_display_scan;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [27:0] d_in;
  logic        lz_en;
  logic [6:0]  data;
  logic [3:0]  an_n;
  logic [1:0]  digit;

  int checks;
  int errors;
  int t;          // edges since reset release
  int skip_dark;  // ticks for which a load may legitimately change data mid-slot
  logic [6:0] exp_word [4];
  logic [6:0] prev_data;

  display_scan #(
    .NDIGITS (4),
    .CLKFREQ (16),
    .SCANFREQ(4),
    .DEAD    (1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .d_in (d_in),
    .lz_en(lz_en),
    .data (data),
    .an_n (an_n),
    .digit(digit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_exp(input logic [6:0] e0, input logic [6:0] e1,
                         input logic [6:0] e2, input logic [6:0] e3);
    exp_word[0] = e0;
    exp_word[1] = e1;
    exp_word[2] = e2;
    exp_word[3] = e3;
  endtask

  // One clock; outputs after edge t reflect cnt/idx as they were before it
  task automatic tick();
    int cp;
    int ip;
    logic [3:0] exp_an;
    @(posedge clk);
    t++;
    @(negedge clk);
    cp = (t - 1) % 4;
    ip = ((t - 1) / 4) % 4;
    exp_an = (cp < 1) ? 4'hF : ~(4'b0001 << ip);
    chk("an_n", {12'd0, an_n}, {12'd0, exp_an});
    chk("digit", {14'd0, digit}, 16'(ip));
    chk("data", {9'd0, data}, {9'd0, exp_word[ip]});
    chk("onehot", 16'(($countones(~an_n) <= 1) ? 1 : 0), 16'd1);
    if (skip_dark == 0 && data !== prev_data)
      chk("dark_change", {12'd0, an_n}, 16'h000F);
    if (skip_dark > 0) skip_dark--;
    prev_data = data;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance until the next edge will sample the given position in the frame
  task automatic advance_to(input int ph);
    for (int i = 0; i < 16 && (t % 16) != ph; i++) tick();
  endtask

  task automatic do_load(input logic [27:0] d, input logic lz,
                         input logic [6:0] e0, input logic [6:0] e1,
                         input logic [6:0] e2, input logic [6:0] e3);
    load      = 1'b1;
    d_in      = d;
    lz_en     = lz;
    skip_dark = 2;
    tick();           // load edge: outputs still show the old shadow
    load = 1'b0;
    set_exp(e0, e1, e2, e3);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    t         = 0;
    skip_dark = 0;
    rst_n     = 1'b0;
    load      = 1'b0;
    d_in      = '0;
    lz_en     = 1'b0;
    set_exp(7'h40, 7'h40, 7'h40, 7'h40);

    // Reset held for three clocks
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_data", {9'd0, data}, 16'h0040);
      chk("rst_an_n", {12'd0, an_n}, 16'h000F);
      chk("rst_digit", {14'd0, digit}, 16'd0);
    end
    prev_data = data;
    rst_n = 1'b1;

    // Free-running scan with blank shadow
    run(20);
    advance_to(0);

    // Plain load, no blanking
    do_load({7'h04, 7'h03, 7'h02, 7'h01}, 1'b0, 7'h01, 7'h02, 7'h03, 7'h04);
    run(16);
    advance_to(0);

    // Leading-zero blanking
    do_load({7'h00, 7'h00, 7'h05, 7'h00}, 1'b1, 7'h00, 7'h05, 7'h40, 7'h40);
    run(16);
    advance_to(0);

    // All zero with blanking: only digit 0 shown
    do_load(28'd0, 1'b1, 7'h00, 7'h40, 7'h40, 7'h40);
    run(16);
    advance_to(0);

    // All zero without blanking: nothing masked
    do_load(28'd0, 1'b0, 7'h00, 7'h00, 7'h00, 7'h00);
    run(16);
    advance_to(0);

    // Already-blank top digit continues the masking
    do_load({7'h40, 7'h00, 7'h00, 7'h03}, 1'b1, 7'h03, 7'h40, 7'h40, 7'h40);
    run(16);
    advance_to(0);

    // Decimal point stops the masking
    do_load({7'h00, 7'h20, 7'h00, 7'h07}, 1'b1, 7'h07, 7'h00, 7'h20, 7'h40);
    // Five full frames with per-cycle one-hot and dead-time checks
    run(80);

    // Back-to-back loads: second one wins
    advance_to(0);
    do_load({7'h11, 7'h11, 7'h11, 7'h11}, 1'b0, 7'h11, 7'h11, 7'h11, 7'h11);
    do_load({7'h00, 7'h10, 7'h00, 7'h00}, 1'b1, 7'h00, 7'h00, 7'h10, 7'h40);
    run(16);

    // Load in the middle of digit 2's slot; scan timing must not shift
    advance_to(9);
    do_load({7'h0A, 7'h0B, 7'h0C, 7'h0D}, 1'b0, 7'h0D, 7'h0C, 7'h0B, 7'h0A);
    run(20);

    // Reset asserted mid-slot, with a coincident load that must be ignored
    advance_to(6);
    rst_n = 1'b0;
    load  = 1'b1;
    d_in  = {7'h01, 7'h01, 7'h01, 7'h01};
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_data", {9'd0, data}, 16'h0040);
    chk("mid_rst_an_n", {12'd0, an_n}, 16'h000F);
    chk("mid_rst_digit", {14'd0, digit}, 16'd0);
    load = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    t     = 0;
    set_exp(7'h40, 7'h40, 7'h40, 7'h40);
    prev_data = data;
    run(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
